// File: rtl/systolic_matmul_param.sv
// systolic_matmul_param: N x N output-stationary systolic multiplier, C = A x B.
// Operands are captured on the accepting start edge. The job then runs for
// exactly 3N-2 cycles, and the result stays in c_flat until the next job
// completes.
// Optional build macro MATMUL_SIGNED_EN: when defined, operands, products and
// accumulation are two's-complement. When undefined, all arithmetic is unsigned.
//
// Handshake: start is a request that is accepted only in IDLE or DONE. The
// module is "ready" exactly when busy is low. On the accepting edge busy
// rises and done falls. busy falls and done rises on the same edge, and that
// edge loads c_flat. done stays high, and c_flat stays valid, until the next
// accepted start. A start seen while busy is dropped; it is not queued.
module systolic_matmul_param #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 2*DW + $clog2(N)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N*N*DW-1:0]     a_flat,
    input  logic [N*N*DW-1:0]     b_flat,
    output logic                  busy,
    output logic                  done,
    output logic [N*N*AW-1:0]     c_flat
);

    // Elaboration-time legality checks
    if (AW < 2*DW + $clog2(N)) begin : g_aw_check
        $error("systolic_matmul_param: AW too small for N and DW");
    end
    if (N < 2 || N > 16) begin : g_n_check
        $error("systolic_matmul_param: N must be in 2..16");
    end

    localparam int LAST = 3*N - 3;
    localparam int SW   = $clog2(3*N - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state_q;
    logic [SW-1:0]         step_q;
    logic                  busy_q;
    logic                  done_q;
    logic [N*N*AW-1:0]     c_q;

    logic [N*N*DW-1:0]     a_op_q;
    logic [N*N*DW-1:0]     b_op_q;

    logic                  accept;
    logic                  run_en;
    logic                  last_step;
    logic [DW-1:0]         a_feed [N];
    logic [DW-1:0]         b_feed [N];
    logic [N*N*AW-1:0]     c_next;

    assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign run_en    = (state_q == ST_RUN);
    assign last_step = run_en && (step_q == SW'(LAST));

    assign busy   = busy_q;
    assign done   = done_q;
    assign c_flat = c_q;

    // Product of two operand elements, extended to accumulator width
    function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MATMUL_SIGNED_EN
        logic signed [2*DW-1:0] p;
        p = $signed(a) * $signed(b);
        return {{(AW-2*DW){p[2*DW-1]}}, p};
`else
        logic [2*DW-1:0] p;
        p = a * b;
        return {{(AW-2*DW){1'b0}}, p};
`endif
    endfunction

    // Control FSM: step counter, handshake flags and result register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (step_q == SW'(LAST)) begin
                        // The final product lands on this same edge, so load
                        // the accumulators' next values rather than their
                        // current ones.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        c_q     <= c_next;
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture on job acceptance; the caller may change inputs afterwards
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_op_q <= '0;
            b_op_q <= '0;
        end else if (accept) begin
            a_op_q <= a_flat;
            b_op_q <= b_flat;
        end
    end

    // Skewed edge feeders: row i gets A[i][k-i], column j gets B[k-j][j]
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            if (int'(step_q) >= i && int'(step_q) - i < N) begin
                a_feed[i] = a_op_q[(i*N + int'(step_q) - i)*DW +: DW];
                b_feed[i] = b_op_q[((int'(step_q) - i)*N + i)*DW +: DW];
            end
        end
    end

    // Processing element array
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [DW-1:0] a_w;
            logic [DW-1:0] b_w;
            logic [DW-1:0] a_q;
            logic [DW-1:0] b_q;
            logic [AW-1:0] acc_q;
            logic [AW-1:0] acc_d;

            if (gj == 0) begin : g_a_edge
                assign a_w = a_feed[gi];
            end else begin : g_a_inner
                assign a_w = g_row[gi].g_col[gj-1].a_q;
            end

            if (gi == 0) begin : g_b_edge
                assign b_w = b_feed[gj];
            end else begin : g_b_inner
                assign b_w = g_row[gi-1].g_col[gj].b_q;
            end

            assign acc_d = acc_q + mul_ext(a_w, b_w);
            assign c_next[(gi*N + gj)*AW +: AW] = acc_d;

            // Multiply-accumulate and operand forwarding, enabled during RUN
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (accept) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (run_en) begin
                    a_q   <= a_w;
                    b_q   <= b_w;
                    acc_q <= acc_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_param.sv
// tb_systolic_matmul_param: directed bench for the systolic multiplier.
// Two instances are used: N=2 and N=4. Both use DW=8 and the default AW.
module tb_systolic_matmul_param;

  localparam int DW  = 8;
  localparam int AW2 = 2*DW + 1;
  localparam int AW4 = 2*DW + 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                 start2 = 1'b0;
  logic [2*2*DW-1:0]    a2 = '0;
  logic [2*2*DW-1:0]    b2 = '0;
  logic                 busy2;
  logic                 done2;
  logic [2*2*AW2-1:0]   c2;

  logic                 start4 = 1'b0;
  logic [4*4*DW-1:0]    a4 = '0;
  logic [4*4*DW-1:0]    b4 = '0;
  logic                 busy4;
  logic                 done4;
  logic [4*4*AW4-1:0]   c4;

  systolic_matmul_param #(.N(2), .DW(DW), .AW(AW2)) dut2 (
    .clock  (clock),
    .reset  (reset),
    .start  (start2),
    .a_flat (a2),
    .b_flat (b2),
    .busy   (busy2),
    .done   (done2),
    .c_flat (c2)
  );

  systolic_matmul_param #(.N(4), .DW(DW), .AW(AW4)) dut4 (
    .clock  (clock),
    .reset  (reset),
    .start  (start4),
    .a_flat (a4),
    .b_flat (b4),
    .busy   (busy4),
    .done   (done4),
    .c_flat (c4)
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];
  int ma[16];
  int mb[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic logic [31:0] mask(input int n, input int v);
    int aw;
    aw = (n == 2) ? AW2 : AW4;
    return 32'(v) & ((32'd1 << aw) - 32'd1);
  endfunction

  function automatic logic get_busy(input int n);
    return (n == 2) ? busy2 : busy4;
  endfunction

  function automatic logic get_done(input int n);
    return (n == 2) ? done2 : done4;
  endfunction

  function automatic logic [31:0] c_elem(input int n, input int idx);
    if (n == 2) return 32'(c2[idx*AW2 +: AW2]);
    return 32'(c4[idx*AW4 +: AW4]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input int n, input logic v);
    if (n == 2) start2 = v;
    else start4 = v;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        if (n == 2) begin
          a2[(i*2+j)*DW +: DW] = 8'(ma[i*n+j]);
          b2[(i*2+j)*DW +: DW] = 8'(mb[i*n+j]);
        end else begin
          a4[(i*4+j)*DW +: DW] = 8'(ma[i*n+j]);
          b4[(i*4+j)*DW +: DW] = 8'(mb[i*n+j]);
        end
      end
    end
  endtask

  // Launch one job and follow it to done. poke=1 re-pulses start and scrambles
  // the inputs mid-run. reset_at>0 pulls reset low at that sample and returns.
  task automatic run_job(input int n, input string tag, input bit poke, input int reset_at);
    int   edges;
    int   busy_cnt;
    logic [31:0] snap[16];
    logic same;
    for (int k = 0; k < n*n; k++) snap[k] = c_elem(n, k);
    @(negedge clock);
    load(n);
    set_start(n, 1'b1);
    edges    = 0;
    busy_cnt = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (edges == 1) set_start(n, 1'b0);
      if (get_busy(n)) busy_cnt++;
      if (edges == 2) begin
        same = 1'b1;
        for (int k = 0; k < n*n; k++) if (c_elem(n, k) !== snap[k]) same = 1'b0;
        check({tag, "_c_hold"}, 32'(same), 32'd1);
      end
      if (poke && edges == 3) begin
        set_start(n, 1'b1);
        for (int k = 0; k < 16; k++) begin
          ma[k] = int'($urandom_range(255, 0));
          mb[k] = int'($urandom_range(255, 0));
        end
        load(n);
      end
      if (poke && edges == 4) set_start(n, 1'b0);
      if (reset_at > 0 && edges == reset_at) begin
        reset = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 32'(get_busy(n)), 32'd0);
        check({tag, "_rst_done"}, 32'(get_done(n)), 32'd0);
        check({tag, "_rst_c"}, 32'((n == 2) ? |c2 : |c4), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        return;
      end
    end while (!get_done(n) && edges < 60);
    check({tag, "_latency"}, 32'(edges), 32'(3*n - 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(3*n - 2));
  endtask

  task automatic check_c(input int n, input string tag);
    logic [31:0] e;
    for (int k = 0; k < n*n; k++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s_c%0d_noexp", tag, k), c_elem(n, k), 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_c%0d", tag, k), c_elem(n, k), e);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;

    // Reset state
    #12;
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_done2", 32'(done2), 32'd0);
    check("rst_c2", 32'(|c2), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_c4", 32'(|c4), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // N=2 basic product
    ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(32'd19); exp_q.push_back(32'd22);
    exp_q.push_back(32'd43); exp_q.push_back(32'd50);
    run_job(2, "n2_basic", 1'b0, 0);
    check_c(2, "n2_basic");
    @(negedge clock);
    check("n2_done_holds", 32'(done2), 32'd1);
    check("n2_idle_busy", 32'(busy2), 32'd0);

    // N=4: identity x B gives B, with no transpose
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i*4+j] = (i == j) ? 1 : 0;
        mb[i*4+j] = 4*i + j;
        exp_q.push_back(32'(4*i + j));
      end
    run_job(4, "n4_idA", 1'b0, 0);
    check_c(4, "n4_idA");

    // N=4: A x identity gives A (exercises the A-side skew)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i*4+j] = 4*i + j + 1;
        mb[i*4+j] = (i == j) ? 1 : 0;
        exp_q.push_back(32'(4*i + j + 1));
      end
    run_job(4, "n4_idB", 1'b0, 0);
    check_c(4, "n4_idB");

    // N=4: diag(1,2,3,4) x B[i][j]=4i+j gives (i+1)*(4i+j)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i*4+j] = (i == j) ? i + 1 : 0;
        mb[i*4+j] = 4*i + j;
        exp_q.push_back(32'((i + 1) * (4*i + j)));
      end
    run_job(4, "n4_diag", 1'b0, 0);
    check_c(4, "n4_diag");

    // N=4: all elements 255 (unsigned 4*255*255, signed 4*(-1)*(-1))
    for (int k = 0; k < 16; k++) begin
      ma[k] = 255;
      mb[k] = 255;
`ifdef MATMUL_SIGNED_EN
      exp_q.push_back(32'd4);
`else
      exp_q.push_back(32'd260100);
`endif
    end
    run_job(4, "n4_max", 1'b0, 0);
    check_c(4, "n4_max");

    // N=2: start pulsed mid-run and inputs scrambled after acceptance
    ma = '{2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(32'd8);  exp_q.push_back(32'd10);
    exp_q.push_back(32'd22); exp_q.push_back(32'd26);
    run_job(2, "n2_poke", 1'b1, 0);
    check_c(2, "n2_poke");

    // N=2: start held high, so done pulses for exactly one cycle per job
    ma = '{2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clock);
    load(2);
    start2 = 1'b1;
    edges  = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end while (!done2 && edges < 60);
    check("held_latency", 32'(edges), 32'd5);
    exp_q.push_back(32'd8);  exp_q.push_back(32'd10);
    exp_q.push_back(32'd22); exp_q.push_back(32'd26);
    check_c(2, "held1");
    @(posedge clock);
    @(negedge clock);
    check("held_done_pulse", 32'(done2), 32'd0);
    check("held_busy_again", 32'(busy2), 32'd1);
    start2 = 1'b0;
    edges  = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end while (!done2 && edges < 60);
    check("held_second_latency", 32'(edges), 32'd4);
    exp_q.push_back(32'd8);  exp_q.push_back(32'd10);
    exp_q.push_back(32'd22); exp_q.push_back(32'd26);
    check_c(2, "held2");

    // N=4: reset at step 3 of a run, then an identity job
    for (int k = 0; k < 16; k++) begin
      ma[k] = 7;
      mb[k] = 9;
    end
    run_job(4, "n4_abort", 1'b0, 4);
    repeat (3) @(negedge clock);
    check("abort_done_low", 32'(done4), 32'd0);
    check("abort_busy_low", 32'(busy4), 32'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i*4+j] = (i == j) ? 1 : 0;
        mb[i*4+j] = (i == j) ? 1 : 0;
        exp_q.push_back((i == j) ? 32'd1 : 32'd0);
      end
    run_job(4, "n4_after_rst", 1'b0, 0);
    check_c(4, "n4_after_rst");

`ifdef MATMUL_SIGNED_EN
    // N=2 signed product
    ma = '{-1, 2, 3, -4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{5, -6, -7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(mask(2, -19)); exp_q.push_back(mask(2, 22));
    exp_q.push_back(mask(2, 43));  exp_q.push_back(mask(2, -50));
    run_job(2, "n2_signed", 1'b0, 0);
    check_c(2, "n2_signed");
`else
    // N=2 operands at the top of the unsigned range
    ma = '{255, 1, 128, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{255, 2, 3, 255, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(mask(2, 65028)); exp_q.push_back(mask(2, 765));
    exp_q.push_back(mask(2, 33240)); exp_q.push_back(mask(2, 51256));
    run_job(2, "n2_unsigned_hi", 1'b0, 0);
    check_c(2, "n2_unsigned_hi");
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
